carus_sram_obi_bridge: RTL and testbench

OBI slave front-end that sits directly upstream of each Carus SRAM bank wrapper on FPGA targets. It converts byte-addressed OBI requests into single-cycle SRAM port accesses and turns the bank's fixed one-cycle read latency into an OBI response channel with `rready` back-pressure. It also sequences the bank's retention input so that the bank only enters retention once all outstanding accesses have drained.

---
 rtl/carus_sram_obi_bridge.sv | 174 +++++++++++++++++
 tb/tb_carus_sram_obi_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carus_sram_obi_bridge.sv
// carus_sram_obi_bridge: OBI slave front-end for a Carus SRAM bank.
// Converts OBI requests into single-cycle bank accesses, buffers the
// one-cycle-latency responses behind rready_i, and sequences bank retention.
// Optional feature macro: CARUS_SRAM_BRIDGE_RETENTION_EN (retention FSM).
module carus_sram_obi_bridge #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned RSP_DEPTH   = 2,
  parameter int unsigned WAKE_CYCLES = 1,
  localparam int unsigned AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [31:0]          rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  output logic                 sram_set_retentive_no,
  input  logic [31:0]          sram_rdata_i,
  input  logic                 ret_req_i,
  output logic                 ret_ack_o
);

  localparam int unsigned CntWidth = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PtrWidth = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                accept_c;
  logic [CntWidth-1:0] cnt_q;
  logic                inflight_q;
  logic                inflight_we_q;
  logic [31:0]         fifo_mem_q [RSP_DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] fifo_cnt_q;
  logic                fifo_empty_c;
  logic [31:0]         rsp_data_c;
  logic                push_c;
  logic                pop_c;
  logic                rsp_done_c;
  logic                unused_c;

  // Request path: grant only when a response slot is guaranteed
  assign gnt_o        = req_i && accept_c && (cnt_q < CntWidth'(RSP_DEPTH));
  assign sram_req_o   = gnt_o;
  assign sram_we_o    = we_i;
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;
  assign sram_addr_o  = addr_i[AddrWidth+1:2];

  // Response path: bypass when FIFO empty, otherwise FIFO head leads
  assign fifo_empty_c = (fifo_cnt_q == '0);
  assign rsp_data_c   = inflight_we_q ? 32'h0 : sram_rdata_i;
  assign rvalid_o     = fifo_empty_c ? inflight_q : 1'b1;
  assign rdata_o      = !fifo_empty_c ? fifo_mem_q[rd_ptr_q] :
                        (inflight_q ? rsp_data_c : 32'h0);
  assign push_c       = inflight_q && !(fifo_empty_c && rready_i);
  assign pop_c        = !fifo_empty_c && rready_i;
  assign rsp_done_c   = rvalid_o && rready_i;

  // In-flight access tracking and outstanding-transaction credit counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      inflight_q    <= gnt_o;
      inflight_we_q <= gnt_o && we_i;
      case ({gnt_o, rsp_done_c})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Response FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) fifo_mem_q[i] <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_c) begin
        fifo_mem_q[wr_ptr_q] <= rsp_data_c;
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      case ({push_c, pop_c})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef CARUS_SRAM_BRIDGE_RETENTION_EN
  localparam int unsigned WakeWidth = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    RETAIN = 2'd2,
    WAKE   = 2'd3
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [WakeWidth-1:0] wake_cnt_q;
  logic                 wake_done_c;

  assign wake_done_c = (wake_cnt_q == WakeWidth'(WAKE_CYCLES - 1));
  assign unused_c    = ^addr_i;

  // Retention state register and wake-up cycle counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ACTIVE;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= (state_q == WAKE) ? wake_cnt_q + WakeWidth'(1) : '0;
    end
  end

  // Next-state logic: drain outstanding accesses before entering retention
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (ret_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!ret_req_i)        state_d = ACTIVE;
        else if (cnt_q == '0)  state_d = RETAIN;
      end
      RETAIN:  if (!ret_req_i) state_d = WAKE;
      WAKE:    if (wake_done_c) state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  // State-decoded outputs; a new retention request blocks grants at once
  always_comb begin
    accept_c              = 1'b0;
    ret_ack_o             = 1'b0;
    sram_set_retentive_no = 1'b1;
    case (state_q)
      ACTIVE: accept_c = !ret_req_i;
      RETAIN: begin
        ret_ack_o             = 1'b1;
        sram_set_retentive_no = 1'b0;
      end
      default: ;
    endcase
  end
`else
  assign accept_c              = 1'b1;
  assign ret_ack_o             = 1'b0;
  assign sram_set_retentive_no = 1'b1;
  assign unused_c              = ^{addr_i, ret_req_i};
`endif

endmodule

// File: tb/tb_carus_sram_obi_bridge.sv
// Directed bench for carus_sram_obi_bridge with a behavioural one-cycle SRAM.
module tb_carus_sram_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [3:0]  sram_be_o;
  logic        sram_set_retentive_no;
  logic [31:0] sram_rdata_i;
  logic        ret_req_i;
  logic        ret_ack_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] mem [1024];

  always #5 clk_i = ~clk_i;

  carus_sram_obi_bridge #(.NUM_WORDS(1024), .RSP_DEPTH(2), .WAKE_CYCLES(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
    .sram_set_retentive_no(sram_set_retentive_no), .sram_rdata_i(sram_rdata_i),
    .ret_req_i(ret_req_i), .ret_ack_o(ret_ack_o)
  );

  // Behavioural bank: byte-enabled write, read data one cycle after request
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge
  task automatic step(input logic rq, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      input logic rr, input logic rt);
    @(posedge clk_i);
    #1;
    req_i = rq; we_i = w; addr_i = a; wdata_i = d; be_i = b;
    rready_i = rr; ret_req_i = rt;
    @(negedge clk_i);
  endtask

  task automatic rd(input logic [31:0] a, input logic rr, input logic rt);
    step(1'b1, 1'b0, a, 32'h0, 4'hF, rr, rt);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic rr, input logic rt);
    step(1'b1, 1'b1, a, d, b, rr, rt);
  endtask

  task automatic idle(input logic rr, input logic rt);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr, rt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    sram_rdata_i = 32'h0;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; be_i = 4'h0;
    wdata_i = 32'h0; rready_i = 1'b1; ret_req_i = 1'b0;

    // Reset values
    #12;
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_sram_req", sram_req_o, 0);
    check("rst_ret_no", sram_set_retentive_no, 1);
    check("rst_ret_ack", ret_ack_o, 0);
    rst_ni = 1'b1;

    // Preload and back-to-back reads with rready high
    wr(32'h18, 32'h0BADF00D, 4'hF, 1'b1, 1'b0);
    check("w18_gnt", gnt_o, 1);
    check("w18_addr", sram_addr_o, 6);
    check("w18_we", sram_we_o, 1);
    check("w18_wdata", sram_wdata_o, 32'h0BADF00D);
    check("w18_be", sram_be_o, 4'hF);
    check("w18_rvalid", rvalid_o, 0);
    wr(32'h14, 32'h600DCAFE, 4'hF, 1'b1, 1'b0);
    check("w14_gnt", gnt_o, 1);
    wr(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    check("w10_gnt", gnt_o, 1);
    rd(32'h10, 1'b1, 1'b0);
    check("b2b_r10_gnt", gnt_o, 1);
    check("b2b_wrsp_rvalid", rvalid_o, 1);
    check("b2b_wrsp_rdata", rdata_o, 0);
    rd(32'h14, 1'b1, 1'b0);
    check("b2b_r14_gnt", gnt_o, 1);
    check("b2b_r10_rvalid", rvalid_o, 1);
    check("b2b_r10_rdata", rdata_o, 32'hDEADBEEF);
    idle(1'b1, 1'b0);
    check("b2b_idle_gnt", gnt_o, 0);
    check("b2b_r14_rvalid", rvalid_o, 1);
    check("b2b_r14_rdata", rdata_o, 32'h600DCAFE);
    idle(1'b1, 1'b0);
    check("b2b_done_rvalid", rvalid_o, 0);

    // Back-pressure: credit limit of 2 with rready low
    rd(32'h10, 1'b0, 1'b0);
    check("bp_g1", gnt_o, 1);
    rd(32'h14, 1'b0, 1'b0);
    check("bp_g2", gnt_o, 1);
    check("bp_c2_rdata", rdata_o, 32'hDEADBEEF);
    rd(32'h18, 1'b0, 1'b0);
    check("bp_full_gnt", gnt_o, 0);
    check("bp_hold_rvalid", rvalid_o, 1);
    check("bp_hold_rdata", rdata_o, 32'hDEADBEEF);
    rd(32'h18, 1'b1, 1'b0);
    check("bp_nocomb_gnt", gnt_o, 0);
    check("bp_rsp1", rdata_o, 32'hDEADBEEF);
    rd(32'h18, 1'b1, 1'b0);
    check("bp_g3", gnt_o, 1);
    check("bp_rsp2_valid", rvalid_o, 1);
    check("bp_rsp2", rdata_o, 32'h600DCAFE);
    idle(1'b1, 1'b0);
    check("bp_rsp3", rdata_o, 32'h0BADF00D);
    idle(1'b1, 1'b0);
    check("bp_done_rvalid", rvalid_o, 0);

    // Byte enables
    wr(32'h20, 32'h11223344, 4'b1111, 1'b1, 1'b0);
    check("be_w1_gnt", gnt_o, 1);
    wr(32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
    check("be_w1_rsp", rdata_o, 0);
    check("be_w1_rvalid", rvalid_o, 1);
    rd(32'h20, 1'b1, 1'b0);
    check("be_w2_rsp", rdata_o, 0);
    check("be_w2_rvalid", rvalid_o, 1);
    idle(1'b1, 1'b0);
    check("be_read", rdata_o, 32'h11BB33DD);
    idle(1'b1, 1'b0);

    // Reset mid-traffic with one FIFO entry pending
    rd(32'h10, 1'b0, 1'b0);
    check("rm_gnt", gnt_o, 1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("rm_pending", rvalid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rm_async_rvalid", rvalid_o, 0);
    check("rm_async_rdata", rdata_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rm_after_rvalid", rvalid_o, 0);
    rd(32'h14, 1'b1, 1'b0);
    check("rm_first_gnt", gnt_o, 1);
    idle(1'b1, 1'b0);
    check("rm_rsp_valid", rvalid_o, 1);
    check("rm_rsp_data", rdata_o, 32'h600DCAFE);
    idle(1'b1, 1'b0);
    check("rm_no_stale", rvalid_o, 0);

`ifdef CARUS_SRAM_BRIDGE_RETENTION_EN
    // Drain before retention, then wake
    rd(32'h10, 1'b0, 1'b0);
    check("ret_g1", gnt_o, 1);
    rd(32'h14, 1'b0, 1'b0);
    check("ret_g2", gnt_o, 1);
    idle(1'b0, 1'b1);
    check("ret_req_ack", ret_ack_o, 0);
    rd(32'h18, 1'b0, 1'b1);
    check("ret_drain_gnt", gnt_o, 0);
    check("ret_drain_ack", ret_ack_o, 0);
    rd(32'h18, 1'b1, 1'b1);
    check("ret_drain_gnt2", gnt_o, 0);
    check("ret_rsp1", rdata_o, 32'hDEADBEEF);
    rd(32'h18, 1'b1, 1'b1);
    check("ret_rsp2", rdata_o, 32'h600DCAFE);
    check("ret_ack_early", ret_ack_o, 0);
    rd(32'h18, 1'b1, 1'b1);
    check("ret_empty_rvalid", rvalid_o, 0);
    check("ret_empty_ack", ret_ack_o, 0);
    check("ret_empty_gnt", gnt_o, 0);
    rd(32'h18, 1'b1, 1'b1);
    check("ret_ack", ret_ack_o, 1);
    check("ret_no", sram_set_retentive_no, 0);
    check("ret_gnt", gnt_o, 0);
    rd(32'h18, 1'b1, 1'b0);
    check("ret_hold_ack", ret_ack_o, 1);
    check("ret_hold_gnt", gnt_o, 0);
    rd(32'h18, 1'b1, 1'b0);
    check("wake_ack", ret_ack_o, 0);
    check("wake_no", sram_set_retentive_no, 1);
    check("wake_gnt", gnt_o, 0);
    rd(32'h18, 1'b1, 1'b0);
    check("resume_gnt", gnt_o, 1);
    idle(1'b1, 1'b0);
    check("resume_rsp", rdata_o, 32'h0BADF00D);
`else
    // Retention request ignored when the feature is compiled out
    rd(32'h10, 1'b1, 1'b1);
    check("noret_g1", gnt_o, 1);
    check("noret_ack1", ret_ack_o, 0);
    check("noret_no1", sram_set_retentive_no, 1);
    rd(32'h14, 1'b1, 1'b0);
    check("noret_g2", gnt_o, 1);
    check("noret_rsp1", rdata_o, 32'hDEADBEEF);
    rd(32'h18, 1'b1, 1'b1);
    check("noret_g3", gnt_o, 1);
    check("noret_rsp2", rdata_o, 32'h600DCAFE);
    check("noret_ack3", ret_ack_o, 0);
    idle(1'b1, 1'b0);
    check("noret_rsp3", rdata_o, 32'h0BADF00D);
    check("noret_no3", sram_set_retentive_no, 1);
`endif

    idle(1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
